async_fifo_rd_ctrl: RTL and testbench

ASYNC_FIFO_RD_CTRL -- requirements
Module: async_fifo_rd_ctrl

---
 rtl/async_fifo_rd_ctrl.sv | 108 ++++++++++
 tb/tb_async_fifo_rd_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_ctrl.sv
// Async FIFO read-side controller. All flops on the falling edge of rclk to
// match the write-side controller. Binary read counter plus registered Gray
// read pointer, two-flop synchronizer for the incoming write pointer, sticky
// underflow flag.
// Optional level logic: define ASYNC_FIFO_RD_LEVEL_EN to get rlevel and a
// level-based ralmost_empty. Without it, rlevel is 0 and ralmost_empty
// follows rempty.
module async_fifo_rd_ctrl #(
    parameter int DEPTH           = 16,
    parameter int FIFO_ADDR_WIDTH = $clog2(DEPTH),
    parameter int AE_THRESH       = 2
) (
    input  logic                       rclk,
    input  logic                       reset,
    input  logic                       rinc,
    input  logic [FIFO_ADDR_WIDTH:0]   rq2_wptr,
    output logic [FIFO_ADDR_WIDTH-1:0] raddr,
    output logic [FIFO_ADDR_WIDTH:0]   rptr,
    output logic                       rempty,
    output logic                       ralmost_empty,
    output logic                       runderflow,
    output logic [FIFO_ADDR_WIDTH:0]   rlevel
);

    // Elaboration-time parameter sanity.
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two >= 4");
    end
    if (AE_THRESH < 0) begin : g_bad_ae
        $error("AE_THRESH must be non-negative");
    end

    logic [FIFO_ADDR_WIDTH:0] r_rbin;
    logic [FIFO_ADDR_WIDTH:0] r_rptr;
    logic [FIFO_ADDR_WIDTH:0] r_sync0;
    logic [FIFO_ADDR_WIDTH:0] r_sync1;
    logic                     r_underflow;

    logic                     w_empty;
    logic                     w_rd_ok;
    logic [FIFO_ADDR_WIDTH:0] w_rbin_next;
    logic [FIFO_ADDR_WIDTH:0] w_rgray_next;

    // Empty compares the registered Gray pointer against the synchronized one,
    // so a write-pointer change shows up on the second falling edge.
    assign w_empty      = (r_rptr == r_sync1);
    assign w_rd_ok      = rinc & ~w_empty;
    assign w_rbin_next  = r_rbin + {{FIFO_ADDR_WIDTH{1'b0}}, w_rd_ok};
    assign w_rgray_next = (w_rbin_next >> 1) ^ w_rbin_next;

    // Read counter and Gray pointer advance together; rptr is a flop so the
    // write domain never sees a glitching multi-bit transition.
    always_ff @(negedge rclk) begin
        if (reset) begin
            r_rbin <= '0;
            r_rptr <= '0;
        end else begin
            r_rbin <= w_rbin_next;
            r_rptr <= w_rgray_next;
        end
    end

    // Two-stage synchronizer for the write-domain Gray pointer.
    always_ff @(negedge rclk) begin
        if (reset) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
        end else begin
            r_sync0 <= rq2_wptr;
            r_sync1 <= r_sync0;
        end
    end

    // Sticky underflow: any read attempt while empty, cleared only by reset.
    always_ff @(negedge rclk) begin
        if (reset)
            r_underflow <= 1'b0;
        else if (rinc && w_empty)
            r_underflow <= 1'b1;
    end

    assign raddr      = r_rbin[FIFO_ADDR_WIDTH-1:0];
    assign rptr       = r_rptr;
    assign rempty     = w_empty;
    assign runderflow = r_underflow;

`ifdef ASYNC_FIFO_RD_LEVEL_EN
    localparam logic [FIFO_ADDR_WIDTH:0] LP_AE = (FIFO_ADDR_WIDTH + 1)'(AE_THRESH);

    logic [FIFO_ADDR_WIDTH:0] w_wbin;

    // Gray-to-binary of the synchronized write pointer: bit i is the XOR of
    // all Gray bits at or above i.
    always_comb begin
        w_wbin = '0;
        for (int i = 0; i <= FIFO_ADDR_WIDTH; i++)
            w_wbin[i] = ^(r_sync1 >> i);
    end

    // Modular difference gives occupancy 0..DEPTH thanks to the extra wrap bit.
    assign rlevel        = w_wbin - r_rbin;
    assign ralmost_empty = (rlevel <= LP_AE);
`else
    assign rlevel        = '0;
    assign ralmost_empty = w_empty;
`endif

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Directed bench for async_fifo_rd_ctrl (DEPTH=16, AE_THRESH=2). The stimulus
// process drives one falling-edge step at a time and queues the expected
// outputs; the monitor pops and compares on the following rising edge.
module tb_async_fifo_rd_ctrl;

    logic       rclk;
    logic       reset;
    logic       rinc;
    logic [4:0] rq2_wptr;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic       rempty;
    logic       ralmost_empty;
    logic       runderflow;
    logic [4:0] rlevel;

    async_fifo_rd_ctrl #(.DEPTH(16), .AE_THRESH(2)) dut (
        .rclk          (rclk),
        .reset         (reset),
        .rinc          (rinc),
        .rq2_wptr      (rq2_wptr),
        .raddr         (raddr),
        .rptr          (rptr),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .runderflow    (runderflow),
        .rlevel        (rlevel)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    typedef struct {
        int         step;
        logic [3:0] raddr;
        logic [4:0] rptr;
        logic       empty;
        logic       ae;
        logic [4:0] lvl;
        logic       uf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   step_no = 0;

    function automatic logic [4:0] gray(input int k);
        logic [4:0] b;
        b = 5'(k);
        return (b >> 1) ^ b;
    endfunction

    task automatic chk(input string nm, input int step, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d actual %0h expected %0h", nm, step, act, exp);
        end
    endtask

    // Drive inputs ahead of the falling edge, then queue what the outputs
    // must look like after it. lvl is the true occupancy; the level-disabled
    // build expects rlevel=0 and ralmost_empty=rempty instead.
    task automatic step(input logic rst, input logic inc, input logic [4:0] w,
                        input logic [3:0] e_raddr, input logic [4:0] e_rptr,
                        input logic e_empty, input logic [4:0] e_lvl, input logic e_uf);
        exp_t e;
        @(posedge rclk);
        #1;
        reset    = rst;
        rinc     = inc;
        rq2_wptr = w;
        @(negedge rclk);
        e.step  = step_no;
        e.raddr = e_raddr;
        e.rptr  = e_rptr;
        e.empty = e_empty;
        e.uf    = e_uf;
`ifdef ASYNC_FIFO_RD_LEVEL_EN
        e.lvl = e_lvl;
        e.ae  = (e_lvl <= 5'd2);
`else
        e.lvl = 5'd0;
        e.ae  = e_empty;
`endif
        q.push_back(e);
        step_no++;
    endtask

    // Monitor: one queued expectation per rising edge.
    always @(posedge rclk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("raddr",         e.step, 32'(raddr),         32'(e.raddr));
            chk("rptr",          e.step, 32'(rptr),          32'(e.rptr));
            chk("rempty",        e.step, 32'(rempty),        32'(e.empty));
            chk("ralmost_empty", e.step, 32'(ralmost_empty), 32'(e.ae));
            chk("rlevel",        e.step, 32'(rlevel),        32'(e.lvl));
            chk("runderflow",    e.step, 32'(runderflow),    32'(e.uf));
        end
    end

    initial begin
        reset    = 1'b1;
        rinc     = 1'b0;
        rq2_wptr = 5'd0;

        // Reset held two edges.
        step(1, 0, 5'b00000, 4'd0, 5'b00000, 1, 5'd0, 0);
        step(1, 0, 5'b00000, 4'd0, 5'b00000, 1, 5'd0, 0);

        // Write pointer 1 becomes visible after the 2nd edge; then one read.
        step(0, 0, 5'b00001, 4'd0, 5'b00000, 1, 5'd0, 0);
        step(0, 0, 5'b00001, 4'd0, 5'b00000, 0, 5'd1, 0);
        step(0, 1, 5'b00001, 4'd1, 5'b00001, 1, 5'd0, 0);

        // Read while empty: pointers hold, underflow sticks.
        step(0, 1, 5'b00001, 4'd1, 5'b00001, 1, 5'd0, 1);
        step(0, 0, 5'b00001, 4'd1, 5'b00001, 1, 5'd0, 1);

        // Reset with rinc high clears everything including underflow.
        step(1, 1, 5'b00001, 4'd0, 5'b00000, 1, 5'd0, 0);

        // Full FIFO (Gray 16), drain 16.
        step(0, 0, 5'b11000, 4'd0, 5'b00000, 1, 5'd0, 0);
        step(0, 0, 5'b11000, 4'd0, 5'b00000, 0, 5'd16, 0);
        for (int k = 1; k <= 16; k++)
            step(0, 1, 5'b11000, 4'(k % 16), gray(k), (k == 16), 5'(16 - k), 0);

        // Another 16 with wptr at 32 mod 32: read counter wraps to 0.
        step(0, 0, 5'b00000, 4'd0, 5'b11000, 1, 5'd0, 0);
        step(0, 0, 5'b00000, 4'd0, 5'b11000, 0, 5'd16, 0);
        for (int k = 17; k <= 32; k++)
            step(0, 1, 5'b00000, 4'(k % 16), gray(k % 32), (k == 32), 5'(32 - k), 0);

        // Almost-empty threshold: level 3 then 2.
        step(0, 0, 5'b00010, 4'd0, 5'b00000, 1, 5'd0, 0);
        step(0, 0, 5'b00010, 4'd0, 5'b00000, 0, 5'd3, 0);
        step(0, 1, 5'b00010, 4'd1, 5'b00001, 0, 5'd2, 0);
        step(0, 1, 5'b00010, 4'd2, 5'b00011, 0, 5'd1, 0);
        step(0, 1, 5'b00010, 4'd3, 5'b00010, 1, 5'd0, 0);

        // Read coinciding with a sync update uses the old (empty) view.
        step(0, 1, 5'b01100, 4'd3, 5'b00010, 1, 5'd0, 1);
        step(0, 1, 5'b01100, 4'd3, 5'b00010, 0, 5'd5, 1);
        step(0, 1, 5'b01100, 4'd4, 5'b00110, 0, 5'd4, 1);
        step(0, 1, 5'b01100, 4'd5, 5'b00111, 0, 5'd3, 1);

        // Mid-operation reset at rbin=5 with rinc high.
        step(1, 1, 5'b01100, 4'd0, 5'b00000, 1, 5'd0, 0);
        step(0, 0, 5'b01100, 4'd0, 5'b00000, 1, 5'd0, 0);

        // Let the monitor drain, bounded.
        for (int i = 0; i < 4 && q.size() > 0; i++)
            @(posedge rclk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
